m_axis_rr_arbiter: RTL

Round-robin arbiter and scheduler that shares one AXI4-Stream master output among NUM_REQ local data producers, such as systolic-array row drainers. Each producer gets bursts of up to BURST_LEN beats through a registered output stage that obeys the full TVALID/TREADY handshake. It sits between the array's result collectors and the single outbound stream toward the DMA/interconnect.

---
 rtl/m_axis_arb_pkg.sv | 16 +
 rtl/m_axis_rr_arbiter_pick.sv | 38 +++
 rtl/m_axis_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/m_axis_arb_pkg.sv
// m_axis_arb_pkg
// Shared definitions for the round-robin AXI4-Stream arbiter:
//   arb_state_t : arbiter FSM state encoding (ST_IDLE, ST_BURST)
//   id_width()  : width of a requester index for a given requester count
package m_axis_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m_axis_rr_arbiter_pick.sv
// arb_rr_pick
// Rotating-priority encoder: returns the first set bit of req at or above
// rr_ptr, searching upward and wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDW      search start index (always < NUM_REQ)
//   found   out 1        at least one request set
//   index   out IDW      selected requester index (0 when none found)
module arb_rr_pick
  import m_axis_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               found,
  output logic [IDW-1:0]     index
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos[IDW-1:0]]) begin
        found = 1'b1;
        index = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/m_axis_rr_arbiter.sv
// m_axis_rr_arbiter
// Round-robin arbiter sharing one AXI4-Stream master among NUM_REQ producers.
// Each grant carries up to BURST_LEN beats through a registered output stage.
// Optional feature macro: M_AXIS_ARB_TLAST_EN (adds TLAST burst framing).
// Ports:
//   clk        in   sole clock, posedge
//   reset_n    in   synchronous active-low reset
//   req_valid  in   NUM_REQ             per-requester valid
//   req_data   in   NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  NUM_REQ             per-requester accept strobe (one-hot or zero)
//   TVALID     out  stream valid
//   TREADY     in   stream ready
//   TDATA      out  DATA_WIDTH          stream data
//   TLAST      out  last beat of a burst (only with M_AXIS_ARB_TLAST_EN)
//   grant_id   out  IDW                 current or last granted requester
//   busy       out  high while a grant is active
//
// state    | meaning
// ST_IDLE  | no grant; pick next requester from rr_ptr, no beat accepted
// ST_BURST | grant_id owns the stream until burst count or a producer gap
module m_axis_rr_arbiter
  import m_axis_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int BURST_LEN  = 16,
  localparam int IDW        = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          TVALID,
  input  logic                          TREADY,
  output logic [DATA_WIDTH-1:0]         TDATA,
`ifdef M_AXIS_ARB_TLAST_EN
  output logic                          TLAST,
`endif
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int               BCW      = $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0]   LAST_CNT = BCW'(BURST_LEN - 1);
  localparam logic [IDW-1:0]   MAX_ID   = IDW'(NUM_REQ - 1);

  arb_state_t            state;
  logic [IDW-1:0]        rr_ptr;
  logic [BCW-1:0]        beat_cnt;
  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;
  logic                  gnt_valid;
  logic                  accept;
  logic                  last_beat;
  logic                  gap;
  logic [IDW-1:0]        next_ptr;
  logic [DATA_WIDTH-1:0] gnt_data;

  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign gnt_valid = req_valid[grant_id];
  // The output register can take a beat when empty or draining this cycle.
  assign accept    = (state == ST_BURST) && gnt_valid && (!TVALID || TREADY);
  assign last_beat = (beat_cnt == LAST_CNT);
  assign gap       = (state == ST_BURST) && !gnt_valid;
  assign next_ptr  = (grant_id == MAX_ID) ? '0 : grant_id + 1'b1;
  assign gnt_data  = req_data[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
  assign busy      = (state == ST_BURST);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      TVALID   <= 1'b0;
      TDATA    <= '0;
`ifdef M_AXIS_ARB_TLAST_EN
      TLAST    <= 1'b0;
`endif
    end else begin
      // Output stage: a held beat survives release and re-arbitration.
      if (accept) begin
        TVALID   <= 1'b1;
        TDATA    <= gnt_data;
        beat_cnt <= beat_cnt + 1'b1;
      end else if (TVALID && TREADY) begin
        TVALID <= 1'b0;
      end

`ifdef M_AXIS_ARB_TLAST_EN
      // A gap only becomes known after the last beat loaded; mark it
      // retroactively if that beat is still held.
      if (accept)
        TLAST <= last_beat;
      else if (TVALID && TREADY)
        TLAST <= 1'b0;
      else if (gap && TVALID)
        TLAST <= 1'b1;
`endif

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (gap || (accept && last_beat)) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
